// File: rtl/fft3_pkg.sv
// Shared types and helpers for the radix-3 butterfly issue controller.
package fft3_pkg;

    localparam int CPLX_W = 64;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] img;
    } cplx_t;

    typedef struct packed {
        cplx_t x0;
        cplx_t x1;
        cplx_t x2;
    } trip_t;

    typedef enum logic [1:0] {
        IDX_A = 2'd0,
        IDX_B = 2'd1,
        IDX_C = 2'd2
    } idx_t;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft3_res_fifo.sv
// Result FIFO of butterfly triplets with a registered head entry.
module fft3_res_fifo
    import fft3_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  trip_t         push_data,
    input  logic          pop,
    output trip_t         rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    trip_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Head register reloads from the next stored entry, or straight from the
    // incoming write when that write becomes the new head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(do_pop);
            if (do_pop) begin
                if (cnt > CW'(1)) rd_data <= mem[rd_ptr + AW'(1)];
                else if (push)    rd_data <= push_data;
            end else if (push && empty) begin
                rd_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/fft3_sched.sv
// Issue controller: groups samples into triplets, credit-gates issue to the
// fixed-latency butterfly and collects results into the output FIFO.
module fft3_sched
    import fft3_pkg::*;
#(
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic        bf_go,
    output logic [63:0] bf_a,
    output logic [63:0] bf_b,
    output logic [63:0] bf_c,
    input  logic [63:0] bf_x0,
    input  logic [63:0] bf_x1,
    input  logic [63:0] bf_x2,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_x0,
    output logic [63:0] m_x1,
    output logic [63:0] m_x2,
    output logic        busy
);

    localparam int CW = clog2(DEPTH + 1);

    idx_t           idx_q, idx_d;
    logic           pending_q, pending_d;
    logic [CW-1:0]  credits_q, credits_d;
    logic [LAT-1:0] vld_q;
    cplx_t          a_q, b_q, c_q;
    trip_t          head;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           take, pop, res_push;

    assign bf_go    = pending_q && (credits_q != '0);
    assign s_ready  = !pending_q || bf_go;
    assign take     = s_valid && s_ready && !flush;
    assign pop      = m_valid && m_ready;
    assign res_push = vld_q[LAT-1];

    assign bf_a    = a_q;
    assign bf_b    = b_q;
    assign bf_c    = c_q;
    assign m_valid = !fifo_empty;
    assign m_x0    = head.x0;
    assign m_x1    = head.x1;
    assign m_x2    = head.x2;
    assign busy    = (idx_q != IDX_A) || pending_q || (|vld_q) || m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= IDX_A;
            pending_q <= 1'b0;
            credits_q <= CW'(DEPTH);
            vld_q     <= '0;
        end else begin
            idx_q     <= idx_d;
            pending_q <= pending_d;
            credits_q <= credits_d;
            vld_q     <= (vld_q << 1) | LAT'(bf_go);
        end
    end

    // A third sample in the issue cycle keeps pending set for the next triplet.
    always_comb begin
        idx_d     = idx_q;
        pending_d = pending_q;
        if (bf_go) pending_d = 1'b0;
        if (flush) begin
            idx_d = IDX_A;
        end else if (take) begin
            case (idx_q)
                IDX_A:   idx_d = IDX_B;
                IDX_B:   idx_d = IDX_C;
                IDX_C: begin
                    idx_d     = IDX_A;
                    pending_d = 1'b1;
                end
                default: idx_d = IDX_A;
            endcase
        end
    end

    always_comb begin
        credits_d = credits_q;
        case ({bf_go, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (take) begin
            case (idx_q)
                IDX_A:   a_q <= s_data;
                IDX_B:   b_q <= s_data;
                IDX_C:   c_q <= s_data;
                default: a_q <= s_data;
            endcase
        end
    end

    fft3_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_push),
        .push_data ({bf_x0, bf_x1, bf_x2}),
        .pop       (pop),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst) !(res_push && fifo_full && !pop));
    assert property (@(posedge clk) disable iff (rst) fifo_count <= CW'(DEPTH) - credits_q);

endmodule
